pgm_wr: RTL and testbench
=========================

# pgm_wr

Write side of the packet generator (PGM): captures one template packet from the UA data path into the 128×144 PGM RAM, forwards traffic unchanged while in bypass, and drives the bypass/start/finish flags consumed by the PGM read side. Sits between the upstream pipeline and the PGM read side, in series on the configuration ring; it is software-controlled via configuration packets addressed to its MID.

## Interface
- LMID, 8'd60, own MID; config packets with cin_wr_data[103:96]==LMID are decoded
- NMID, 8'd61, next MID (documentation only; no logic)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_wr_phv / in_wr_phv_wr  in  1024/1  PHV from upstream
- in_wr_data / in_wr_data_wr  in  134/1  flit; [133:132] 01 head, 11 middle, 10 tail; [131:128] valid bytes of tail
- in_wr_valid / in_wr_valid_wr  in  1/1  packet-valid sideband
- out_wr_phv_alf, out_wr_alf  out  1  combinational copies of in_wr_phv_alf, in_wr_alf
- out_wr_phv / out_wr_phv_wr, out_wr_data / out_wr_data_wr, out_wr_valid / out_wr_valid_wr  out  1024/1, 134/1, 1/1  registered forward path to PGM read side
- in_wr_phv_alf, in_wr_alf  in  1  downstream almost-full
- wr2ram_wr  out  1  RAM write strobe
- wr2ram_addr  out  7  RAM address
- wr2ram_wdata  out  144  {10'b0, flit}
- pgm_bypass_flag  out  1  level, 1 = forward traffic
- pgm_sent_start_flag  out  1  one-cycle pulse, begin generation
- pgm_sent_finish_flag  out  1  level, stop after current packet
- cin_wr_data / cin_wr_data_wr  in  134/1  config ring input
- cout_wr_ready  out  1  = cin_wr_ready
- cout_wr_data / cout_wr_data_wr  out  134/1  config ring output, registered
- cin_wr_ready  in  1  downstream config ready

## Operation
- States: IDLE, ARM, CAPT, DROP, READY, RUN, FIN.
- IDLE: pgm_bypass_flag=1; every input flit/PHV/valid forwarded 1 cycle later. Internal in_pkt tracks head..tail.
- Arm command (write 0x00020001 data[0]=1) sets arm_req; IDLE→ARM only when in_pkt=0 (no truncation of forwarded packet).
- ARM..FIN: pgm_bypass_flag=0; nothing forwarded (out_*_wr=0).
- ARM: on head flit write RAM addr 0, →CAPT. Non-head flits ignored.
- CAPT: each flit written at addr+1. Tail → READY, template_flits=addr+1. If addr reaches 127 with non-tail flit: flit written with [133:132] forced 10, [131:128]=0, →DROP.
- DROP: discard until tail, →READY.
- READY: start command (0x00020002 data[0]=1) → pgm_sent_start_flag=1 for exactly one cycle, →RUN.
- RUN: stop command (0x00020003 data[0]=1) → pgm_sent_finish_flag=1 held, →FIN.
- FIN: hold until soft reset.
- Input packets in READY/RUN/FIN dropped whole.
- Start in states other than READY and stop outside RUN ignored.
- Config write: head flit, [126:124]==3'b010, MID match; addr in [95:64], data [31:0]; packet forwarded unchanged. 0x00000000 data[0]=soft_rst.
- Config read: [126:124]==3'b001, MID match → forwarded with [127:124]=4'b1011 and [31:0]: 0x00000000 soft_rst, 0x00020000 state (zero-extended), 0x00020004 template_flits; unknown addr → 32'hffffffff. Non-matching flits forwarded unchanged, one-cycle latency.
- soft_rst: self-clearing one cycle after set; resets all state and outputs as rst_n except RAM contents and config path. Mid-capture soft reset → IDLE, template invalid.

## Timing
- Reset: all out_*, wr2ram_*, cout_wr_data_wr = 0; pgm_bypass_flag = 1; start/finish = 0; state IDLE.
- Forward and RAM write latency: flit sampled at cycle t appears at t+1.
- Start pulse: cycle after start command's head flit.
- Finish flag: rises cycle after stop command.
- Head and tail in same cycle: impossible by protocol; not handled.
- Arm command and head flit in same cycle in IDLE: head forwarded, arm taken after its tail.

## Configuration
- PGM_WR_STAT_EN defined: 32-bit counters fwd_pkt_cnt (tails forwarded, read 0x00020005) and drop_pkt_cnt (tails dropped, incl. DROP state, read 0x00020006); wrap at 2^32; cleared by reset/soft reset.
- Undefined: counters absent; both addresses read 32'hffffffff.

## Test plan
- Bypass: 4-flit packet in IDLE → identical 4 flits on out_wr_* 1 cycle later; no wr2ram_wr.
- Capture: arm, send 5-flit packet → wr2ram_wr at addr 0..4, template_flits read back 5, state READY, nothing forwarded.
- Truncation: arm, send 200-flit packet → 128 writes, addr 127 data[133:132]=10, remaining 72 flits discarded, state READY.
- Start/stop: in READY write start → start pulse exactly 1 cycle; write stop → finish flag 1 and held until soft reset.
- Soft reset mid-capture after 3 flits → state IDLE, bypass flag 1; next packet forwarded.
- PGM_WR_STAT_EN: 3 forwarded, then 2 dropped in RUN → reads 3 and 2; without macro → 0xffffffff.

Source files
------------

// File: rtl/pgm_wr.sv
// PGM write side: bypass forwarding, single-template capture into the PGM RAM, start/finish flags.
// Define PGM_WR_STAT_EN to add forwarded/dropped packet counters readable over the config ring.
module pgm_wr #(
    parameter logic [7:0] LMID = 8'd60,
    parameter logic [7:0] NMID = 8'd61
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic [1023:0]  in_wr_phv,
    input  logic           in_wr_phv_wr,
    input  logic [133:0]   in_wr_data,
    input  logic           in_wr_data_wr,
    input  logic           in_wr_valid,
    input  logic           in_wr_valid_wr,
    output logic           out_wr_phv_alf,
    output logic           out_wr_alf,

    output logic [1023:0]  out_wr_phv,
    output logic           out_wr_phv_wr,
    output logic [133:0]   out_wr_data,
    output logic           out_wr_data_wr,
    output logic           out_wr_valid,
    output logic           out_wr_valid_wr,
    input  logic           in_wr_phv_alf,
    input  logic           in_wr_alf,

    output logic           wr2ram_wr,
    output logic [6:0]     wr2ram_addr,
    output logic [143:0]   wr2ram_wdata,

    output logic           pgm_bypass_flag,
    output logic           pgm_sent_start_flag,
    output logic           pgm_sent_finish_flag,

    input  logic [133:0]   cin_wr_data,
    input  logic           cin_wr_data_wr,
    output logic           cout_wr_ready,
    output logic [133:0]   cout_wr_data,
    output logic           cout_wr_data_wr,
    input  logic           cin_wr_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        CAPT  = 3'd2,
        DROP  = 3'd3,
        READY = 3'd4,
        RUN   = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic            in_pkt_q, in_pkt_d;
    logic            arm_req_q, arm_req_d;
    logic            soft_rst_q, soft_rst_d;
    logic            start_q, start_d;
    logic            finish_q, finish_d;
    logic            bypass_q, bypass_d;
    logic [6:0]      cap_addr_q, cap_addr_d;
    logic [7:0]      tmpl_flits_q, tmpl_flits_d;

    logic [1023:0]   out_phv_q, out_phv_d;
    logic            out_phv_wr_q, out_phv_wr_d;
    logic [133:0]    out_data_q, out_data_d;
    logic            out_data_wr_q, out_data_wr_d;
    logic            out_valid_q, out_valid_d;
    logic            out_valid_wr_q, out_valid_wr_d;

    logic            ram_wr_q, ram_wr_d;
    logic [6:0]      ram_addr_q, ram_addr_d;
    logic [143:0]    ram_wdata_q, ram_wdata_d;

    logic [133:0]    cout_data_q, cout_data_d;
    logic            cout_data_wr_q, cout_data_wr_d;

    logic            in_hdr, in_tail;
    logic            cfg_hit, cfg_wr, cfg_rd;
    logic [31:0]     cfg_addr, cfg_wdat, rd_val;
    logic            arm_cmd, start_cmd, stop_cmd, srst_cmd;
    logic            fwd_tail, drop_tail;

    assign in_hdr   = in_wr_data_wr && (in_wr_data[133:132] == 2'b01);
    assign in_tail  = in_wr_data_wr && (in_wr_data[133:132] == 2'b10);

    assign cfg_hit  = cin_wr_data_wr && (cin_wr_data[133:132] == 2'b01) && (cin_wr_data[103:96] == LMID);
    assign cfg_wr   = cfg_hit && (cin_wr_data[126:124] == 3'b010);
    assign cfg_rd   = cfg_hit && (cin_wr_data[126:124] == 3'b001);
    assign cfg_addr = cin_wr_data[95:64];
    assign cfg_wdat = cin_wr_data[31:0];

    assign srst_cmd  = cfg_wr && (cfg_addr == 32'h0000_0000) && cfg_wdat[0];
    assign arm_cmd   = cfg_wr && (cfg_addr == 32'h0002_0001) && cfg_wdat[0];
    assign start_cmd = cfg_wr && (cfg_addr == 32'h0002_0002) && cfg_wdat[0];
    assign stop_cmd  = cfg_wr && (cfg_addr == 32'h0002_0003) && cfg_wdat[0];

`ifdef PGM_WR_STAT_EN
    logic [31:0] fwd_pkt_cnt_q, fwd_pkt_cnt_d;
    logic [31:0] drop_pkt_cnt_q, drop_pkt_cnt_d;

    always_comb begin
        fwd_pkt_cnt_d  = fwd_pkt_cnt_q + {31'b0, fwd_tail};
        drop_pkt_cnt_d = drop_pkt_cnt_q + {31'b0, drop_tail};
        if (soft_rst_q) begin
            fwd_pkt_cnt_d  = '0;
            drop_pkt_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_pkt_cnt_q  <= '0;
            drop_pkt_cnt_q <= '0;
        end else begin
            fwd_pkt_cnt_q  <= fwd_pkt_cnt_d;
            drop_pkt_cnt_q <= drop_pkt_cnt_d;
        end
    end
`endif

    always_comb begin
        rd_val = '1;
        case (cfg_addr)
            32'h0000_0000: rd_val = {31'b0, soft_rst_q};
            32'h0002_0000: rd_val = {29'b0, state_q};
            32'h0002_0004: rd_val = {24'b0, tmpl_flits_q};
`ifdef PGM_WR_STAT_EN
            32'h0002_0005: rd_val = fwd_pkt_cnt_q;
            32'h0002_0006: rd_val = drop_pkt_cnt_q;
`endif
            default:       rd_val = '1;
        endcase
    end

    // Config ring path is outside the soft-reset domain so the write that raised it still propagates.
    always_comb begin
        cout_data_d    = cin_wr_data;
        cout_data_wr_d = cin_wr_data_wr;
        if (cfg_rd) begin
            cout_data_d[127:124] = 4'b1011;
            cout_data_d[31:0]    = rd_val;
        end
        soft_rst_d = soft_rst_q ? 1'b0 : srst_cmd;
    end

    always_comb begin
        state_d        = state_q;
        in_pkt_d       = in_hdr ? 1'b1 : (in_tail ? 1'b0 : in_pkt_q);
        arm_req_d      = arm_req_q;
        start_d        = 1'b0;
        finish_d       = finish_q;
        cap_addr_d     = cap_addr_q;
        tmpl_flits_d   = tmpl_flits_q;
        out_phv_d      = '0;
        out_phv_wr_d   = 1'b0;
        out_data_d     = '0;
        out_data_wr_d  = 1'b0;
        out_valid_d    = 1'b0;
        out_valid_wr_d = 1'b0;
        ram_wr_d       = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        fwd_tail       = 1'b0;
        drop_tail      = 1'b0;

        case (state_q)
            IDLE: begin
                out_phv_d      = in_wr_phv;
                out_phv_wr_d   = in_wr_phv_wr;
                out_data_d     = in_wr_data;
                out_data_wr_d  = in_wr_data_wr;
                out_valid_d    = in_wr_valid;
                out_valid_wr_d = in_wr_valid_wr;
                fwd_tail       = in_tail;
                if (arm_cmd)
                    arm_req_d = 1'b1;
                // A head arriving now is forwarded; arming waits for that packet's tail.
                if (arm_req_q && !in_pkt_q && !in_hdr) begin
                    arm_req_d = 1'b0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (in_hdr) begin
                    ram_wr_d    = 1'b1;
                    ram_addr_d  = 7'd0;
                    ram_wdata_d = {10'b0, in_wr_data};
                    cap_addr_d  = 7'd0;
                    state_d     = CAPT;
                end else begin
                    drop_tail = in_tail;
                end
            end
            CAPT: begin
                if (in_wr_data_wr) begin
                    ram_wr_d    = 1'b1;
                    ram_addr_d  = cap_addr_q + 7'd1;
                    ram_wdata_d = {10'b0, in_wr_data};
                    cap_addr_d  = cap_addr_q + 7'd1;
                    if (in_tail) begin
                        tmpl_flits_d = {1'b0, cap_addr_q} + 8'd2;
                        state_d      = READY;
                    end else if (cap_addr_q == 7'd126) begin
                        // Last RAM slot: close the template with a synthetic zero-byte tail.
                        ram_wdata_d[133:128] = 6'b10_0000;
                        tmpl_flits_d         = 8'd128;
                        state_d              = DROP;
                    end
                end
            end
            DROP: begin
                if (in_tail) begin
                    drop_tail = 1'b1;
                    state_d   = READY;
                end
            end
            READY: begin
                drop_tail = in_tail;
                if (start_cmd) begin
                    start_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                drop_tail = in_tail;
                if (stop_cmd) begin
                    finish_d = 1'b1;
                    state_d  = FIN;
                end
            end
            FIN: begin
                drop_tail = in_tail;
            end
            default: state_d = IDLE;
        endcase

        if (soft_rst_q) begin
            state_d        = IDLE;
            in_pkt_d       = 1'b0;
            arm_req_d      = 1'b0;
            start_d        = 1'b0;
            finish_d       = 1'b0;
            cap_addr_d     = '0;
            tmpl_flits_d   = '0;
            out_phv_d      = '0;
            out_phv_wr_d   = 1'b0;
            out_data_d     = '0;
            out_data_wr_d  = 1'b0;
            out_valid_d    = 1'b0;
            out_valid_wr_d = 1'b0;
            ram_wr_d       = 1'b0;
            ram_addr_d     = '0;
            ram_wdata_d    = '0;
            fwd_tail       = 1'b0;
            drop_tail      = 1'b0;
        end

        bypass_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            in_pkt_q       <= 1'b0;
            arm_req_q      <= 1'b0;
            soft_rst_q     <= 1'b0;
            start_q        <= 1'b0;
            finish_q       <= 1'b0;
            bypass_q       <= 1'b1;
            cap_addr_q     <= '0;
            tmpl_flits_q   <= '0;
            out_phv_q      <= '0;
            out_phv_wr_q   <= 1'b0;
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            ram_wr_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            cout_data_q    <= '0;
            cout_data_wr_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_pkt_q       <= in_pkt_d;
            arm_req_q      <= arm_req_d;
            soft_rst_q     <= soft_rst_d;
            start_q        <= start_d;
            finish_q       <= finish_d;
            bypass_q       <= bypass_d;
            cap_addr_q     <= cap_addr_d;
            tmpl_flits_q   <= tmpl_flits_d;
            out_phv_q      <= out_phv_d;
            out_phv_wr_q   <= out_phv_wr_d;
            out_data_q     <= out_data_d;
            out_data_wr_q  <= out_data_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            ram_wr_q       <= ram_wr_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            cout_data_q    <= cout_data_d;
            cout_data_wr_q <= cout_data_wr_d;
        end
    end

    assign out_wr_phv_alf       = in_wr_phv_alf;
    assign out_wr_alf           = in_wr_alf;
    assign out_wr_phv           = out_phv_q;
    assign out_wr_phv_wr        = out_phv_wr_q;
    assign out_wr_data          = out_data_q;
    assign out_wr_data_wr       = out_data_wr_q;
    assign out_wr_valid         = out_valid_q;
    assign out_wr_valid_wr      = out_valid_wr_q;
    assign wr2ram_wr            = ram_wr_q;
    assign wr2ram_addr          = ram_addr_q;
    assign wr2ram_wdata         = ram_wdata_q;
    assign pgm_bypass_flag      = bypass_q;
    assign pgm_sent_start_flag  = start_q;
    assign pgm_sent_finish_flag = finish_q;
    assign cout_wr_ready        = cin_wr_ready;
    assign cout_wr_data         = cout_data_q;
    assign cout_wr_data_wr      = cout_data_wr_q;

endmodule

// File: tb/tb_pgm_wr.sv
// Directed bench for pgm_wr: vector tables for bypass and config-ring reads, plus sequences
// for capture, truncation, start/stop, soft reset and the optional statistics counters.
module tb_pgm_wr;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1023:0]  in_wr_phv = '0;
    logic           in_wr_phv_wr = 1'b0;
    logic [133:0]   in_wr_data = '0;
    logic           in_wr_data_wr = 1'b0;
    logic           in_wr_valid = 1'b0;
    logic           in_wr_valid_wr = 1'b0;
    logic           out_wr_phv_alf, out_wr_alf;
    logic [1023:0]  out_wr_phv;
    logic           out_wr_phv_wr;
    logic [133:0]   out_wr_data;
    logic           out_wr_data_wr;
    logic           out_wr_valid, out_wr_valid_wr;
    logic           in_wr_phv_alf = 1'b0;
    logic           in_wr_alf = 1'b0;
    logic           wr2ram_wr;
    logic [6:0]     wr2ram_addr;
    logic [143:0]   wr2ram_wdata;
    logic           pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
    logic [133:0]   cin_wr_data = '0;
    logic           cin_wr_data_wr = 1'b0;
    logic           cout_wr_ready;
    logic [133:0]   cout_wr_data;
    logic           cout_wr_data_wr;
    logic           cin_wr_ready = 1'b0;

    pgm_wr #(.LMID(8'd60), .NMID(8'd61)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr),
        .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr),
        .in_wr_valid(in_wr_valid), .in_wr_valid_wr(in_wr_valid_wr),
        .out_wr_phv_alf(out_wr_phv_alf), .out_wr_alf(out_wr_alf),
        .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr),
        .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr),
        .out_wr_valid(out_wr_valid), .out_wr_valid_wr(out_wr_valid_wr),
        .in_wr_phv_alf(in_wr_phv_alf), .in_wr_alf(in_wr_alf),
        .wr2ram_wr(wr2ram_wr), .wr2ram_addr(wr2ram_addr), .wr2ram_wdata(wr2ram_wdata),
        .pgm_bypass_flag(pgm_bypass_flag),
        .pgm_sent_start_flag(pgm_sent_start_flag),
        .pgm_sent_finish_flag(pgm_sent_finish_flag),
        .cin_wr_data(cin_wr_data), .cin_wr_data_wr(cin_wr_data_wr),
        .cout_wr_ready(cout_wr_ready),
        .cout_wr_data(cout_wr_data), .cout_wr_data_wr(cout_wr_data_wr),
        .cin_wr_ready(cin_wr_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0]   ram_a[$];
    logic [143:0] ram_d[$];
    int           fwd_flits = 0;

    always @(negedge clk) begin
        if (wr2ram_wr) begin
            ram_a.push_back(wr2ram_addr);
            ram_d.push_back(wr2ram_wdata);
        end
        if (out_wr_data_wr)
            fwd_flits++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [133:0] mk_cfg(input logic [1:0] ft, input logic [7:0] mid,
                                            input logic [3:0] typ, input logic [31:0] addr,
                                            input logic [31:0] data);
        logic [133:0] f;
        f          = '0;
        f[133:132] = ft;
        f[127:124] = typ;
        f[103:96]  = mid;
        f[95:64]   = addr;
        f[63:32]   = 32'hFEED_0001;
        f[31:0]    = data;
        return f;
    endfunction

    function automatic logic [133:0] mk_flit(input int i, input int n, input logic [7:0] tag);
        logic [133:0] f;
        f          = '0;
        f[133:132] = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
        f[131:128] = (i == n - 1) ? 4'd8 : 4'd0;
        f[127:120] = tag;
        f[119:88]  = i;
        f[63:0]    = 64'h0123_4567_89AB_CDEF ^ {32'h0, i};
        return f;
    endfunction

    task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cin_wr_data    = mk_cfg(2'b01, 8'd60, 4'b0010, addr, data);
        cin_wr_data_wr = 1'b1;
        @(negedge clk);
        cin_wr_data    = '0;
        cin_wr_data_wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        cin_wr_data    = mk_cfg(2'b01, 8'd60, 4'b0001, addr, 32'h0);
        cin_wr_data_wr = 1'b1;
        @(negedge clk);
        cin_wr_data    = '0;
        cin_wr_data_wr = 1'b0;
        chk(name, {cout_wr_data_wr, cout_wr_data[127:124], cout_wr_data[31:0]},
            {1'b1, 4'b1011, exp});
    endtask

    task automatic send_pkt(input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_wr_data    = mk_flit(i, n, tag);
            in_wr_data_wr = 1'b1;
        end
        @(negedge clk);
        in_wr_data    = '0;
        in_wr_data_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [133:0]  d;  logic dw;  logic [1023:0] p;  logic pw;  logic v;  logic vw;
        logic [133:0]  ed; logic edw; logic [1023:0] ep; logic epw; logic ev; logic evw;
    } bvec_t;

    typedef struct {
        logic [133:0] ci;
        logic [133:0] eco;
    } cvec_t;

    bvec_t bv[5];
    cvec_t cv[8];

    initial begin
        int f0, bad;
        logic [133:0] e;

        // Bypass vectors: a 4-flit packet with PHV on the head and valid on the tail, then a gap.
        bv[0] = '{134'h1_0000_0000_0000_0000_0000_0000_1111_1111, 1'b1, 1024'hABC0, 1'b1, 1'b0, 1'b0,
                  134'h1_0000_0000_0000_0000_0000_0000_1111_1111, 1'b1, 1024'hABC0, 1'b1, 1'b0, 1'b0};
        bv[1] = '{134'h3_0000_0000_0000_0000_0000_0000_2222_2222, 1'b1, 1024'h0, 1'b0, 1'b0, 1'b0,
                  134'h3_0000_0000_0000_0000_0000_0000_2222_2222, 1'b1, 1024'h0, 1'b0, 1'b0, 1'b0};
        bv[2] = '{134'h3_0000_0000_0000_0000_0000_0000_3333_3333, 1'b1, 1024'h0, 1'b0, 1'b0, 1'b0,
                  134'h3_0000_0000_0000_0000_0000_0000_3333_3333, 1'b1, 1024'h0, 1'b0, 1'b0, 1'b0};
        bv[3] = '{134'h2_C000_0000_0000_0000_0000_0000_4444_4444, 1'b1, 1024'h0, 1'b0, 1'b1, 1'b1,
                  134'h2_C000_0000_0000_0000_0000_0000_4444_4444, 1'b1, 1024'h0, 1'b0, 1'b1, 1'b1};
        bv[4] = '{134'h0, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b0,
                  134'h0, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b0};

        // Config ring vectors, all issued right after reset (state IDLE, template 0).
        cv[0] = '{mk_cfg(2'b01, 8'd60, 4'b0001, 32'h0002_0000, 32'hDEAD_BEEF),
                  mk_cfg(2'b01, 8'd60, 4'b1011, 32'h0002_0000, 32'h0000_0000)};
        cv[1] = '{mk_cfg(2'b01, 8'd61, 4'b0001, 32'h0002_0000, 32'h1234_5678),
                  mk_cfg(2'b01, 8'd61, 4'b0001, 32'h0002_0000, 32'h1234_5678)};
        cv[2] = '{mk_cfg(2'b01, 8'd60, 4'b0001, 32'h0001_0000, 32'h0),
                  mk_cfg(2'b01, 8'd60, 4'b1011, 32'h0001_0000, 32'hFFFF_FFFF)};
        cv[3] = '{mk_cfg(2'b01, 8'd60, 4'b0001, 32'h0002_0004, 32'h5),
                  mk_cfg(2'b01, 8'd60, 4'b1011, 32'h0002_0004, 32'h0)};
        cv[4] = '{mk_cfg(2'b11, 8'd60, 4'b0001, 32'h0002_0000, 32'h7),
                  mk_cfg(2'b11, 8'd60, 4'b0001, 32'h0002_0000, 32'h7)};
        cv[5] = '{mk_cfg(2'b01, 8'd60, 4'b0010, 32'h0002_0004, 32'h9),
                  mk_cfg(2'b01, 8'd60, 4'b0010, 32'h0002_0004, 32'h9)};
        cv[6] = '{mk_cfg(2'b01, 8'd60, 4'b0001, 32'h0000_0000, 32'h0),
                  mk_cfg(2'b01, 8'd60, 4'b1011, 32'h0000_0000, 32'h0)};
`ifdef PGM_WR_STAT_EN
        cv[7] = '{mk_cfg(2'b01, 8'd60, 4'b0001, 32'h0002_0005, 32'h0),
                  mk_cfg(2'b01, 8'd60, 4'b1011, 32'h0002_0005, 32'h0)};
`else
        cv[7] = '{mk_cfg(2'b01, 8'd60, 4'b0001, 32'h0002_0005, 32'h0),
                  mk_cfg(2'b01, 8'd60, 4'b1011, 32'h0002_0005, 32'hFFFF_FFFF)};
`endif

        // ---- reset state ----
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_wr", {out_wr_data_wr, out_wr_phv_wr, out_wr_valid_wr, out_wr_data}, '0);
        chk("rst_ram", {wr2ram_wr, wr2ram_addr, wr2ram_wdata}, '0);
        chk("rst_flags", {pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag, cout_wr_data_wr}, 4'b1000);
        in_wr_alf = 1'b1; cin_wr_ready = 1'b1;
        #1;
        chk("passthru_alf", {out_wr_alf, out_wr_phv_alf, cout_wr_ready}, 3'b101);
        in_wr_alf = 1'b0; in_wr_phv_alf = 1'b1; cin_wr_ready = 1'b0;
        #1;
        chk("passthru_alf2", {out_wr_alf, out_wr_phv_alf, cout_wr_ready}, 3'b010);
        in_wr_phv_alf = 1'b0;

        // ---- config ring table ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cin_wr_data = cv[i].ci; cin_wr_data_wr = 1'b1;
            @(negedge clk);
            cin_wr_data = '0; cin_wr_data_wr = 1'b0;
            chk($sformatf("cfg_vec%0d", i), {cout_wr_data_wr, cout_wr_data}, {1'b1, cv[i].eco});
        end

        // ---- bypass table ----
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_wr_data = bv[i].d; in_wr_data_wr = bv[i].dw;
            in_wr_phv = bv[i].p; in_wr_phv_wr = bv[i].pw;
            in_wr_valid = bv[i].v; in_wr_valid_wr = bv[i].vw;
            @(negedge clk);
            chk($sformatf("byp_data%0d", i), {out_wr_data_wr, out_wr_data}, {bv[i].edw, bv[i].ed});
            chk($sformatf("byp_phv%0d", i), {out_wr_phv_wr, out_wr_phv}, {bv[i].epw, bv[i].ep});
            chk($sformatf("byp_vld%0d", i), {out_wr_valid_wr, out_wr_valid, wr2ram_wr, pgm_bypass_flag},
                {bv[i].evw, bv[i].ev, 1'b0, 1'b1});
        end
        in_wr_phv = '0; in_wr_phv_wr = 1'b0; in_wr_valid = 1'b0; in_wr_valid_wr = 1'b0;
        idle(2);
        chk("byp_no_ram", ram_a.size(), 0);

        // ---- capture a 5-flit template ----
        cfg_wr(32'h0002_0001, 32'h1);
        idle(2);
        rd_chk("arm_state", 32'h0002_0000, 32'd1);
        chk("arm_bypass", pgm_bypass_flag, 1'b0);
        ram_a.delete(); ram_d.delete();
        f0 = fwd_flits;
        send_pkt(5, 8'h5A);
        idle(2);
        chk("cap_nwr", ram_a.size(), 5);
        for (int i = 0; i < 5 && i < ram_a.size(); i++) begin
            chk($sformatf("cap_addr%0d", i), ram_a[i], i);
            chk($sformatf("cap_data%0d", i), ram_d[i], {10'b0, mk_flit(i, 5, 8'h5A)});
        end
        chk("cap_no_fwd", fwd_flits - f0, 0);
        rd_chk("cap_tmpl", 32'h0002_0004, 32'd5);
        rd_chk("cap_state", 32'h0002_0000, 32'd4);

        // ---- truncation of a 200-flit packet ----
        cfg_wr(32'h0, 32'h1);
        idle(3);
        rd_chk("srst_state", 32'h0002_0000, 32'd0);
        cfg_wr(32'h0002_0001, 32'h1);
        idle(2);
        ram_a.delete(); ram_d.delete();
        f0 = fwd_flits;
        send_pkt(200, 8'hC3);
        idle(2);
        chk("trunc_nwr", ram_a.size(), 128);
        bad = 0;
        for (int i = 0; i < 128 && i < ram_a.size(); i++) begin
            e = mk_flit(i, 200, 8'hC3);
            if (i == 127) e[133:128] = 6'b10_0000;
            if (ram_a[i] !== 7'(i) || ram_d[i] !== {10'b0, e}) bad++;
        end
        chk("trunc_bad_entries", bad, 0);
        if (ram_d.size() >= 128)
            chk("trunc_last_type", ram_d[127][133:128], 6'b10_0000);
        chk("trunc_no_fwd", fwd_flits - f0, 0);
        rd_chk("trunc_state", 32'h0002_0000, 32'd4);
        rd_chk("trunc_tmpl", 32'h0002_0004, 32'd128);

        // ---- start / stop ----
        cfg_wr(32'h0002_0003, 32'h1);
        idle(1);
        chk("stop_in_ready_ignored", pgm_sent_finish_flag, 1'b0);
        rd_chk("stop_in_ready_state", 32'h0002_0000, 32'd4);
        cfg_wr(32'h0002_0002, 32'h1);
        chk("start_pulse_hi", pgm_sent_start_flag, 1'b1);
        @(negedge clk);
        chk("start_pulse_lo", pgm_sent_start_flag, 1'b0);
        rd_chk("run_state", 32'h0002_0000, 32'd5);
        cfg_wr(32'h0002_0003, 32'h1);
        chk("finish_rise", pgm_sent_finish_flag, 1'b1);
        idle(5);
        chk("finish_held", {pgm_sent_finish_flag, pgm_bypass_flag}, 2'b10);
        cfg_wr(32'h0002_0002, 32'h1);
        chk("start_in_fin_ignored", pgm_sent_start_flag, 1'b0);
        rd_chk("fin_state", 32'h0002_0000, 32'd6);
        cfg_wr(32'h0, 32'h1);
        idle(3);
        chk("fin_srst_flags", {pgm_sent_finish_flag, pgm_bypass_flag}, 2'b01);
        rd_chk("srst_selfclear", 32'h0, 32'd0);

        // ---- soft reset mid-capture ----
        cfg_wr(32'h0002_0001, 32'h1);
        idle(2);
        ram_a.delete(); ram_d.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_wr_data = mk_flit(i, 6, 8'h77); in_wr_data_wr = 1'b1;
        end
        @(negedge clk);
        in_wr_data = '0; in_wr_data_wr = 1'b0;
        cfg_wr(32'h0, 32'h1);
        idle(3);
        chk("mid_nwr", ram_a.size(), 3);
        chk("mid_bypass", pgm_bypass_flag, 1'b1);
        rd_chk("mid_state", 32'h0002_0000, 32'd0);
        rd_chk("mid_tmpl", 32'h0002_0004, 32'd0);
        f0 = fwd_flits;
        send_pkt(4, 8'h44);
        idle(2);
        chk("mid_next_fwd", fwd_flits - f0, 4);
        chk("mid_next_noram", ram_a.size(), 3);

        // ---- arm coincident with head, then statistics ----
        cfg_wr(32'h0, 32'h1);
        idle(3);
        f0 = fwd_flits;
        send_pkt(3, 8'h01);
        send_pkt(3, 8'h02);
        @(negedge clk);
        in_wr_data = mk_flit(0, 3, 8'h03); in_wr_data_wr = 1'b1;
        cin_wr_data = mk_cfg(2'b01, 8'd60, 4'b0010, 32'h0002_0001, 32'h1); cin_wr_data_wr = 1'b1;
        @(negedge clk);
        cin_wr_data = '0; cin_wr_data_wr = 1'b0;
        in_wr_data = mk_flit(1, 3, 8'h03);
        @(negedge clk);
        in_wr_data = mk_flit(2, 3, 8'h03);
        @(negedge clk);
        in_wr_data = '0; in_wr_data_wr = 1'b0;
        idle(2);
        chk("arm_after_tail_fwd", fwd_flits - f0, 9);
        rd_chk("arm_after_tail_state", 32'h0002_0000, 32'd1);
        send_pkt(2, 8'h10);
        idle(1);
        rd_chk("stat_tmpl", 32'h0002_0004, 32'd2);
        cfg_wr(32'h0002_0002, 32'h1);
        idle(1);
        send_pkt(2, 8'h20);
        send_pkt(2, 8'h21);
        idle(2);
        chk("run_drop_fwd", fwd_flits - f0, 9);
`ifdef PGM_WR_STAT_EN
        rd_chk("stat_fwd", 32'h0002_0005, 32'd3);
        rd_chk("stat_drop", 32'h0002_0006, 32'd2);
`else
        rd_chk("stat_fwd_absent", 32'h0002_0005, 32'hFFFF_FFFF);
        rd_chk("stat_drop_absent", 32'h0002_0006, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
